// File: rtl/hwpe_stream_protocol_checker_pkg.sv
// hwpe_stream_protocol_checker_pkg: error record type and helpers shared by the checker.
package hwpe_stream_protocol_checker_pkg;
  localparam int HWPE_STREAM_CHK_ERR_W = 3;
  typedef struct packed {
    logic timeout;
    logic vdr;
    logic vcr;
  } hwpe_stream_chk_err_t;
  function automatic int chk_ch_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/hwpe_stream_protocol_checker_if.sv
// hwpe_stream_protocol_checker_if: HWPE stream (valid/ready/data/strb) with master, slave and monitor views.
interface hwpe_stream_protocol_checker_if #(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH > 8 ? DATA_WIDTH / 8 : 1
) ();
  logic valid;
  logic ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;
  modport master (output valid, data, strb, input ready);
  modport slave (input valid, data, strb, output ready);
  modport monitor (input valid, ready, data, strb);
endinterface

// File: rtl/hwpe_stream_protocol_checker_channel.sv
// hwpe_stream_checker_channel: one stream's history, VCR/VDR rules, sticky flags, handshake counter
// and, with HWPE_STREAM_CHECKER_TIMEOUT_EN, a stall watchdog.
module hwpe_stream_checker_channel
  import hwpe_stream_protocol_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 4,
  parameter int CNT_WIDTH = 32,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic valid,
  input  logic ready,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [STRB_WIDTH-1:0] strb,
  input  logic [TIMEOUT_WIDTH-1:0] timeout,
  output hwpe_stream_chk_err_t hit,
  output hwpe_stream_chk_err_t err,
  output logic [CNT_WIDTH-1:0] hs_cnt
);
  logic q, pv, pr, viol, to_hit;
  logic [DATA_WIDTH-1:0] pd;
  logic [STRB_WIDTH-1:0] ps;
  assign viol = enable & q & pv & ~pr;
  assign hit = '{timeout: to_hit, vdr: viol & ~valid, vcr: viol & (data != pd || strb != ps)};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {q, pv, pr, pd, ps} <= '0;
      err <= '0;
      hs_cnt <= '0;
    end else if (clear) begin
      {q, pv, pr, pd, ps} <= '0;
      err <= '0;
      hs_cnt <= '0;
    end else begin
      {q, pv, pr, pd, ps} <= {enable, valid, ready, data, strb};
      err <= err | hit;
      if (enable & valid & ready & ~&hs_cnt) hs_cnt <= hs_cnt + CNT_WIDTH'(1);
    end
`ifdef HWPE_STREAM_CHECKER_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] stall;
  logic stalled;
  assign stalled = enable & valid & ~ready;
  // Fire on the stalled cycle that brings the count to the threshold, then hold there.
  assign to_hit = stalled & (|timeout) & (stall + TIMEOUT_WIDTH'(1) == timeout);
  always_ff @(posedge clk or posedge rst)
    if (rst) stall <= '0;
    else if (clear | ~stalled) stall <= '0;
    else if (!((|timeout) && stall == timeout) && ~&stall) stall <= stall + TIMEOUT_WIDTH'(1);
`else
  logic unused;
  assign unused = ^timeout;
  assign to_hit = 1'b0;
`endif
endmodule

// File: rtl/hwpe_stream_protocol_checker.sv
// hwpe_stream_protocol_checker: multi-channel HWPE stream rule checker with sticky flags and first-error capture.
// Define HWPE_STREAM_CHECKER_TIMEOUT_EN to build the per-channel stall watchdog.
module hwpe_stream_protocol_checker
  import hwpe_stream_protocol_checker_pkg::*;
#(
  parameter int NB_CHANNELS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH > 8 ? DATA_WIDTH / 8 : 1,
  parameter int CNT_WIDTH = 32,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  hwpe_stream_protocol_checker_if.monitor mon [NB_CHANNELS],
  input  logic [TIMEOUT_WIDTH-1:0] timeout_i,
  output logic [NB_CHANNELS-1:0] err_vcr_o,
  output logic [NB_CHANNELS-1:0] err_vdr_o,
  output logic [NB_CHANNELS-1:0] err_timeout_o,
  output logic err_any_o,
  output logic first_err_valid_o,
  output logic [chk_ch_w(NB_CHANNELS)-1:0] first_err_ch_o,
  output logic [HWPE_STREAM_CHK_ERR_W-1:0] first_err_type_o,
  output logic [NB_CHANNELS-1:0][CNT_WIDTH-1:0] hs_cnt_o
);
  localparam int CH_W = chk_ch_w(NB_CHANNELS);
  hwpe_stream_chk_err_t [NB_CHANNELS-1:0] hit, err;
  hwpe_stream_chk_err_t sel_hit;
  logic [CH_W-1:0] sel_ch;
  for (genvar c = 0; c < NB_CHANNELS; c++) begin : g_ch
    hwpe_stream_checker_channel #(
      .DATA_WIDTH(DATA_WIDTH),
      .STRB_WIDTH(STRB_WIDTH),
      .CNT_WIDTH(CNT_WIDTH),
      .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
    ) u_ch (
      .clk(clk_i),
      .rst(rst_i),
      .clear(clear_i),
      .enable(enable_i),
      .valid(mon[c].valid),
      .ready(mon[c].ready),
      .data(mon[c].data),
      .strb(mon[c].strb),
      .timeout(timeout_i),
      .hit(hit[c]),
      .err(err[c]),
      .hs_cnt(hs_cnt_o[c])
    );
    assign err_vcr_o[c] = err[c].vcr;
    assign err_vdr_o[c] = err[c].vdr;
    assign err_timeout_o[c] = err[c].timeout;
  end
  assign err_any_o = |{err_vcr_o, err_vdr_o, err_timeout_o};
  // Scan downwards so the lowest hitting channel is the one left selected.
  always_comb begin
    sel_ch = '0;
    sel_hit = '0;
    for (int i = NB_CHANNELS - 1; i >= 0; i--)
      if (|hit[i]) begin
        sel_ch = CH_W'(i);
        sel_hit = hit[i];
      end
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      first_err_valid_o <= 1'b0;
      first_err_ch_o <= '0;
      first_err_type_o <= '0;
    end else if (clear_i) begin
      first_err_valid_o <= 1'b0;
      first_err_ch_o <= '0;
      first_err_type_o <= '0;
    end else if (!first_err_valid_o && |hit) begin
      first_err_valid_o <= 1'b1;
      first_err_ch_o <= sel_ch;
      first_err_type_o <= sel_hit;
    end
endmodule

// File: tb/tb_hwpe_stream_protocol_checker.sv
// tb_hwpe_stream_protocol_checker: scoreboard bench; a behavioural model queues the expected outputs per cycle.
module tb_hwpe_stream_protocol_checker;
  localparam int N = 4, DW = 32, SW = 4, CW = 4, TW = 16;
  logic clk = 1'b0, rst, clr, en;
  logic [TW-1:0] tmo;
  always #5 clk = ~clk;
  logic v[N], r[N];
  logic [DW-1:0] d[N];
  logic [SW-1:0] s[N];
  hwpe_stream_protocol_checker_if #(.DATA_WIDTH(DW), .STRB_WIDTH(SW)) mon [N] ();
  for (genvar g = 0; g < N; g++) begin : g_drv
    assign mon[g].valid = v[g];
    assign mon[g].ready = r[g];
    assign mon[g].data = d[g];
    assign mon[g].strb = s[g];
  end
  logic [N-1:0] err_vcr, err_vdr, err_to;
  logic err_any, fv;
  logic [1:0] fch;
  logic [2:0] ftype;
  logic [N-1:0][CW-1:0] hs;
  hwpe_stream_protocol_checker #(
    .NB_CHANNELS(N), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .CNT_WIDTH(CW), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .enable_i(en), .mon(mon), .timeout_i(tmo),
    .err_vcr_o(err_vcr), .err_vdr_o(err_vdr), .err_timeout_o(err_to), .err_any_o(err_any),
    .first_err_valid_o(fv), .first_err_ch_o(fch), .first_err_type_o(ftype), .hs_cnt_o(hs)
  );
  typedef struct packed {
    logic [N-1:0] vcr, vdr, to;
    logic any, fv;
    logic [1:0] fch;
    logic [2:0] ft;
    logic [N-1:0][CW-1:0] hs;
  } exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0;
  logic mpv[N], mpr[N], mq, mfv;
  logic [DW-1:0] mpd[N];
  logic [SW-1:0] mps[N];
  logic [2:0] merr[N], mft;
  int mcnt[N], mstall[N], mfch;
`ifdef HWPE_STREAM_CHECKER_TIMEOUT_EN
  localparam logic WD = 1'b1;
`else
  localparam logic WD = 1'b0;
`endif
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    mq = 0; mfv = 0; mfch = 0; mft = 0;
    for (int i = 0; i < N; i++) begin
      mpv[i] = 0; mpr[i] = 0; mpd[i] = 0; mps[i] = 0; merr[i] = 0; mcnt[i] = 0; mstall[i] = 0;
    end
  endtask
  task automatic model_step();
    logic [2:0] h[N];
    logic vio, stl;
    int lo = -1;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      vio = en & mq & mpv[i] & ~mpr[i];
      stl = en & v[i] & ~r[i];
      h[i][0] = vio & (d[i] != mpd[i] || s[i] != mps[i]);
      h[i][1] = vio & ~v[i];
      h[i][2] = WD & stl & (tmo != 0) & (mstall[i] + 1 == int'(tmo));
      if (lo < 0 && h[i] != 0) lo = i;
    end
    if (clr) model_reset();
    else begin
      if (!mfv && lo >= 0) begin mfv = 1; mfch = lo; mft = h[lo]; end
      for (int i = 0; i < N; i++) begin
        merr[i] |= h[i];
        if (en & v[i] & r[i] && mcnt[i] < 15) mcnt[i]++;
        if (!(en & v[i] & ~r[i])) mstall[i] = 0;
        else if (!(tmo != 0 && mstall[i] == int'(tmo))) mstall[i]++;
        mpv[i] = v[i]; mpr[i] = r[i]; mpd[i] = d[i]; mps[i] = s[i];
      end
      mq = en;
    end
    e = '0;
    for (int i = 0; i < N; i++) begin
      e.vcr[i] = merr[i][0]; e.vdr[i] = merr[i][1]; e.to[i] = merr[i][2];
      e.hs[i] = CW'(mcnt[i]);
    end
    e.any = |{e.vcr, e.vdr, e.to};
    e.fv = mfv; e.fch = 2'(mfch); e.ft = mft;
    sb.push_back(e);
  endtask
  task automatic cyc();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("vcr", 32'(err_vcr), 32'(e.vcr));
    check("vdr", 32'(err_vdr), 32'(e.vdr));
    check("timeout", 32'(err_to), 32'(e.to));
    check("any", 32'(err_any), 32'(e.any));
    check("first_valid", 32'(fv), 32'(e.fv));
    check("first_ch", 32'(fch), 32'(e.fch));
    check("first_type", 32'(ftype), 32'(e.ft));
    check("hs_cnt", 32'(hs), 32'(e.hs));
  endtask
  task automatic check_zero(string tag);
    check({tag, "_flags"}, 32'({err_vcr, err_vdr, err_to, err_any}), 0);
    check({tag, "_first"}, 32'({fv, fch, ftype}), 0);
    check({tag, "_hs"}, 32'(hs), 0);
  endtask
  task automatic pulse_clear();
    clr = 1; cyc();
    clr = 0; cyc();
  endtask
  initial begin
    rst = 1; clr = 0; en = 0; tmo = 0;
    for (int i = 0; i < N; i++) begin v[i] = 0; r[i] = 0; d[i] = 0; s[i] = '1; end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 0; en = 1;
    // VCR on channel 0
    v[0] = 1; d[0] = 32'hA5A5A5A5; repeat (2) cyc();
    d[0] = 32'h5A5A5A5A; cyc();
    check("s1_vcr", 32'(err_vcr), 32'b0001);
    check("s1_ch", 32'(fch), 0);
    check("s1_type", 32'(ftype), 32'b001);
    r[0] = 1; cyc();
    v[0] = 0; r[0] = 0; cyc();
    // VDR on channel 2
    pulse_clear();
    v[2] = 1; d[2] = 32'h1234; repeat (2) cyc();
    v[2] = 0; cyc();
    check("s2_vdr", 32'(err_vdr), 32'b0100);
    check("s2_vcr", 32'(err_vcr), 0);
    check("s2_type", 32'(ftype), 32'b010);
    check("s2_any", 32'(err_any), 1);
    // simultaneous VCR on channels 1 and 3, later VDR on 3
    pulse_clear();
    v[1] = 1; v[3] = 1; d[1] = 1; d[3] = 3; repeat (2) cyc();
    d[1] = 11; d[3] = 33; cyc();
    check("s3_vcr", 32'(err_vcr), 32'b1010);
    check("s3_ch", 32'(fch), 1);
    r[1] = 1; v[3] = 0; cyc();
    check("s3_vdr", 32'(err_vdr), 32'b1000);
    check("s3_ch_hold", 32'(fch), 1);
    check("s3_type_hold", 32'(ftype), 32'b001);
    v[1] = 0; r[1] = 0; cyc();
    // handshake counting and saturation
    pulse_clear();
    v[1] = 1; r[1] = 1;
    for (int i = 0; i < 10; i++) begin d[1] = i; cyc(); end
    check("s4_hs10", 32'(hs[1]), 10);
    en = 0;
    for (int i = 0; i < 5; i++) begin d[1] = 100 + i; cyc(); end
    check("s4_hs_disabled", 32'(hs[1]), 10);
    en = 1;
    for (int i = 0; i < 10; i++) begin d[1] = 200 + i; cyc(); end
    check("s4_hs_sat", 32'(hs[1]), 15);
    v[1] = 0; r[1] = 0; cyc();
    // clear beats a simultaneous hit; checks resume two cycles later
    v[0] = 1; d[0] = 1; repeat (2) cyc();
    d[0] = 2; cyc();
    check("s5_raised", 32'(err_any), 1);
    clr = 1; d[0] = 3; cyc();
    check_zero("s5_clear");
    clr = 0; d[0] = 4; cyc();
    check("s5_q_low", 32'(err_vcr), 0);
    d[0] = 5; cyc();
    check("s5_resumed", 32'(err_vcr), 32'b0001);
    v[0] = 0; cyc();
    // stall watchdog
    pulse_clear();
    tmo = 8; v[0] = 1; d[0] = 7;
    repeat (7) cyc();
    check("s6_to7", 32'(err_to), 0);
    cyc();
    check("s6_to8", 32'(err_to), 32'(WD));
    repeat (4) cyc();
    pulse_clear();
    tmo = 0; repeat (20) cyc();
    check("s6_to_off", 32'(err_to), 0);
    v[0] = 0; cyc();
    // asynchronous reset mid-stream
    v[2] = 1; d[2] = 9; repeat (2) cyc();
    d[2] = 10; cyc();
    check("s7_pre", 32'(err_vcr), 32'b0100);
    #2 rst = 1;
    #1;
    model_reset();
    sb.delete();
    check_zero("s7_async");
    @(posedge clk);
    #1 rst = 0;
    d[2] = 11; cyc();
    check("s7_skip", 32'(err_vcr), 0);
    d[2] = 12; cyc();
    check("s7_after", 32'(err_vcr), 32'b0100);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
